// File: rtl/load_weight_multi_pkg.sv
// Shared types, constants and helpers for the multi-channel kernel weight loader.
package load_weight_multi_pkg;

    // Loader sequencing: wait for a request, issue KK reads, drain the
    // read pipeline, then publish every channel in one edge.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } lw_state_e;

    // Default configuration of the loader.
    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_KSIZE         = 3;
    localparam int DEF_WEIGHT_WIDTH  = 8;
    localparam int DEF_BRAM_ADDR_BIT = 32;
    localparam int DEF_BRAM_WIDTH    = 32;
    localparam int DEF_RD_LAT        = 1;

    // Widest BRAM word the lane selector can handle.
    localparam int MAX_WORD_WIDTH = 512;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Number of weights packed into one BRAM word.
    function automatic int lanes_of(input int bram_width, input int weight_width);
        return bram_width / weight_width;
    endfunction

    // Number of weights in one square kernel.
    function automatic int kk_of(input int ksize);
        return ksize * ksize;
    endfunction

    // Address bits that pick a lane inside a BRAM word.
    function automatic int lane_bits_of(input int bram_width, input int weight_width);
        return clog2(lanes_of(bram_width, weight_width));
    endfunction

    // Pick lane 'offset' out of a word; lane 0 sits in the least significant
    // bits because the BRAM is byte addressed little-endian style.
    function automatic logic [MAX_WORD_WIDTH-1:0] lane_select(
        input logic [MAX_WORD_WIDTH-1:0] word,
        input int unsigned               offset,
        input int unsigned               weight_width
    );
        logic [MAX_WORD_WIDTH-1:0] mask;
        mask = '1;
        mask = ~(mask << weight_width);
        return (word >> (offset * weight_width)) & mask;
    endfunction

endpackage

// File: rtl/load_weight_multi_capture.sv
// Per-channel read-return path: delays the issue valid and lane offset by the
// BRAM latency, extracts the addressed lane and files it into the shadow
// register selected by the running capture index.
module weight_lane_capture
    import load_weight_multi_pkg::*;
#(
    parameter int KK           = 9,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BRAM_WIDTH   = 32,
    parameter int RD_LAT       = 1,
    parameter int OFF_W        = 2,
    parameter int IDX_W        = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       issue_i,
    input  logic [OFF_W-1:0]           offset_i,
    input  logic [BRAM_WIDTH-1:0]      dout_i,
    output logic                       capture_o,
    output logic [IDX_W-1:0]           cap_idx_o,
    output logic [KK*WEIGHT_WIDTH-1:0] shadow_o
);

    logic [RD_LAT-1:0]       vld_q;
    logic [OFF_W-1:0]        off_q [RD_LAT];
    logic [IDX_W-1:0]        cap_idx_q;
    logic [IDX_W-1:0]        cap_idx_d;
    logic [WEIGHT_WIDTH-1:0] shadow_q [KK];
    logic [WEIGHT_WIDTH-1:0] lane_word;
    logic                    capture;
    logic                    room;

    // Delay line so the valid bit and lane offset line up with the read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                off_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= issue_i;
            off_q[0] <= offset_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                off_q[i] <= off_q[i-1];
            end
        end
    end

    assign capture   = vld_q[RD_LAT-1];
    assign room      = (cap_idx_q < IDX_W'(KK));
    assign lane_word = WEIGHT_WIDTH'(lane_select(MAX_WORD_WIDTH'(dout_i),
                                                 32'(off_q[RD_LAT-1]),
                                                 32'(WEIGHT_WIDTH)));

    // Capture index restarts with every accepted load and counts captured weights.
    always_comb begin
        cap_idx_d = cap_idx_q;
        if (clear_i) begin
            cap_idx_d = '0;
        end else if (capture && room) begin
            cap_idx_d = cap_idx_q + IDX_W'(1);
        end
    end

    // Shadow register file; entries are only overwritten by captured lanes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_idx_q <= '0;
            for (int i = 0; i < KK; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            cap_idx_q <= cap_idx_d;
            for (int i = 0; i < KK; i++) begin
                if (capture && room && (cap_idx_q == IDX_W'(i))) begin
                    shadow_q[i] <= lane_word;
                end
            end
        end
    end

    // Flatten with weight 0 in the most significant slot.
    always_comb begin
        shadow_o = '0;
        for (int i = 0; i < KK; i++) begin
            shadow_o[(KK-1-i)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = shadow_q[i];
        end
    end

    assign capture_o = capture;
    assign cap_idx_o = cap_idx_q;

endmodule

// File: rtl/load_weight_multi.sv
// Multi-channel kernel weight loader: streams one kernel per channel from
// byte-addressed BRAM ports into shadow registers and publishes all channels
// to the conv engine in a single edge so the engine never sees a partial load.
module load_weight_multi
    import load_weight_multi_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int KSIZE         = DEF_KSIZE,
    parameter int WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH,
    parameter int BRAM_ADDR_BIT = DEF_BRAM_ADDR_BIT,
    parameter int BRAM_WIDTH    = DEF_BRAM_WIDTH,
    parameter int RD_LAT        = DEF_RD_LAT
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      load_start,
    input  logic                                      addr_rst,
    input  logic [BRAM_ADDR_BIT-1:0]                  base_addr,
    output logic                                      busy,
    output logic                                      load_end,
    output logic [NUM_CH*KSIZE*KSIZE*WEIGHT_WIDTH-1:0] weight,
    output logic                                      BRAM_clk,
    output logic                                      BRAM_en,
    output logic                                      BRAM_rst,
    output logic [BRAM_WIDTH-1:0]                     BRAM_din,
    output logic [BRAM_WIDTH/8-1:0]                   BRAM_wen,
    output logic [NUM_CH*BRAM_ADDR_BIT-1:0]           BRAM_addr,
    input  logic [NUM_CH*BRAM_WIDTH-1:0]              BRAM_dout
);

    localparam int KK        = kk_of(KSIZE);
    localparam int LANES     = lanes_of(BRAM_WIDTH, WEIGHT_WIDTH);
    localparam int LANE_BITS = clog2(LANES);
    localparam int OFF_W     = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int CNT_W     = clog2(KK + 1);
    localparam int CH_W      = KK * WEIGHT_WIDTH;

    lw_state_e                  state_q, state_d;
    logic [BRAM_ADDR_BIT-1:0]   cursor_q, cursor_d;
    logic [CNT_W-1:0]           issue_cnt_q, issue_cnt_d;
    logic                       busy_q, busy_d;
    logic                       load_end_q, load_end_d;
    logic                       pend_q, pend_d;
    logic [BRAM_ADDR_BIT-1:0]   pend_addr_q, pend_addr_d;
    logic [NUM_CH*CH_W-1:0]     weight_q;

    logic                       start_load;
    logic                       issue;
    logic                       commit;
    logic [OFF_W-1:0]           issue_off;
    logic [NUM_CH*CH_W-1:0]     shadow_all;
    logic [CNT_W-1:0]           cap_idx [NUM_CH];
    logic [NUM_CH-1:0]          capture;
    logic [NUM_CH-1:0]          ch_done;
    logic                       all_done;

    // The lane offset travels with each issued read; a single-lane word has no offset.
    assign issue_off = (LANE_BITS > 0) ? cursor_q[OFF_W-1:0] : '0;

    // One capture path per channel; every channel sees the same cursor, so
    // they all finish on the same edge.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        weight_lane_capture #(
            .KK           (KK),
            .WEIGHT_WIDTH (WEIGHT_WIDTH),
            .BRAM_WIDTH   (BRAM_WIDTH),
            .RD_LAT       (RD_LAT),
            .OFF_W        (OFF_W),
            .IDX_W        (CNT_W)
        ) u_capture (
            .clk_i     (clk),
            .rst_ni    (rst),
            .clear_i   (start_load),
            .issue_i   (issue),
            .offset_i  (issue_off),
            .dout_i    (BRAM_dout[ch*BRAM_WIDTH +: BRAM_WIDTH]),
            .capture_o (capture[ch]),
            .cap_idx_o (cap_idx[ch]),
            .shadow_o  (shadow_all[ch*CH_W +: CH_W])
        );

        // A channel is done once all KK weights are in, or the last one lands this edge.
        assign ch_done[ch] = (cap_idx[ch] == CNT_W'(KK)) ||
                             (capture[ch] && (cap_idx[ch] == CNT_W'(KK - 1)));
    end

    assign all_done = &ch_done;

    // Next-state logic: rewinds, read issue, drain wait and the single commit cycle.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        issue_cnt_d = issue_cnt_q;
        busy_d      = busy_q;
        load_end_d  = 1'b0;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        start_load  = 1'b0;
        issue       = 1'b0;
        commit      = 1'b0;

        // A rewind requested mid-load is parked until the loader is idle again.
        if ((state_q != ST_IDLE) && addr_rst) begin
            pend_d      = 1'b1;
            pend_addr_d = base_addr;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (addr_rst) begin
                    cursor_d = base_addr;
                end else if (pend_q) begin
                    cursor_d = pend_addr_q;
                end
                pend_d = 1'b0;
                if (load_start) begin
                    state_d     = ST_ISSUE;
                    busy_d      = 1'b1;
                    start_load  = 1'b1;
                    issue_cnt_d = '0;
                end
            end
            ST_ISSUE: begin
                issue       = 1'b1;
                cursor_d    = cursor_q + BRAM_ADDR_BIT'(1);
                issue_cnt_d = issue_cnt_q + CNT_W'(1);
                if (issue_cnt_q == CNT_W'(KK - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (all_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit     = 1'b1;
                load_end_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers plus the published weights, which only move on the commit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cursor_q    <= '0;
            issue_cnt_q <= '0;
            busy_q      <= 1'b0;
            load_end_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            weight_q    <= '0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            issue_cnt_q <= issue_cnt_d;
            busy_q      <= busy_d;
            load_end_q  <= load_end_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            if (commit) begin
                weight_q <= shadow_all;
            end
        end
    end

    assign busy      = busy_q;
    assign load_end  = load_end_q;
    assign weight    = weight_q;
    assign BRAM_addr = {NUM_CH{cursor_q}};

    // The BRAM ports are read-only and always enabled.
    assign BRAM_clk = clk;
    assign BRAM_en  = 1'b1;
    assign BRAM_rst = 1'b0;
    assign BRAM_din = '0;
    assign BRAM_wen = '0;

endmodule

// File: tb/tb_load_weight_multi.sv
// Bench for load_weight_multi: a default instance (A) and a KSIZE=5, RD_LAT=3,
// two-channel instance (B), each fed by a behavioural BRAM whose byte at
// address a on channel c is (a + 16c)[7:0]. An abstract load model predicts
// busy, load_end, weight and BRAM_addr every cycle.
module tb_load_weight_multi;

    logic        clk;
    logic        rst;
    logic        ldS   [2];
    logic        arS   [2];
    logic [31:0] baseS [2];

    logic         busyA, leA, bclkA, benA, brstA;
    logic [287:0] weightA;
    logic [31:0]  bdinA;
    logic [3:0]   bwenA;
    logic [127:0] baddrA, bdoutA;

    logic         busyB, leB, bclkB, benB, brstB;
    logic [399:0] weightB;
    logic [31:0]  bdinB;
    logic [3:0]   bwenB;
    logic [63:0]  baddrB, bdoutB;
    logic [63:0]  pipeB [3];

    int passes;
    int checks;
    int fails;
    bit chkEn;

    // Abstract model state, one slot per DUT.
    logic [31:0]  mCursor [2];
    logic [31:0]  mStart  [2];
    logic [31:0]  mPendAddr [2];
    bit           mPend [2];
    bit           mBusy [2];
    bit           mLe   [2];
    int           mT    [2];
    logic [399:0] mW    [2];

    string        tag;
    logic [399:0] obsW;
    logic [31:0]  expAddr;
    logic [31:0]  obsAddr;

    load_weight_multi u_dutA (
        .clk(clk), .rst(rst), .load_start(ldS[0]), .addr_rst(arS[0]), .base_addr(baseS[0]),
        .busy(busyA), .load_end(leA), .weight(weightA),
        .BRAM_clk(bclkA), .BRAM_en(benA), .BRAM_rst(brstA), .BRAM_din(bdinA), .BRAM_wen(bwenA),
        .BRAM_addr(baddrA), .BRAM_dout(bdoutA)
    );

    load_weight_multi #(.NUM_CH(2), .KSIZE(5), .RD_LAT(3)) u_dutB (
        .clk(clk), .rst(rst), .load_start(ldS[1]), .addr_rst(arS[1]), .base_addr(baseS[1]),
        .busy(busyB), .load_end(leB), .weight(weightB),
        .BRAM_clk(bclkB), .BRAM_en(benB), .BRAM_rst(brstB), .BRAM_din(bdinB), .BRAM_wen(bwenB),
        .BRAM_addr(baddrB), .BRAM_dout(bdoutB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int kkOf(input int d);
        return (d == 0) ? 9 : 25;
    endfunction

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int nchOf(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic logic [7:0] byteAt(input int ch, input logic [31:0] a);
        return 8'(a + 32'(16 * ch));
    endfunction

    function automatic logic [31:0] wordAt(input int ch, input logic [31:0] a);
        logic [31:0] aw;
        aw = a & 32'hFFFF_FFFC;
        return {byteAt(ch, aw + 32'd3), byteAt(ch, aw + 32'd2), byteAt(ch, aw + 32'd1), byteAt(ch, aw)};
    endfunction

    // Kernel as the conv engine must see it after a load starting at address s.
    function automatic logic [399:0] expWeights(input int d, input logic [31:0] s);
        logic [399:0] r;
        int k;
        r = '0;
        k = kkOf(d);
        for (int ch = 0; ch < nchOf(d); ch++) begin
            for (int i = 0; i < k; i++) begin
                r[(ch*k + (k-1-i))*8 +: 8] = byteAt(ch, s + 32'(i));
            end
        end
        return r;
    endfunction

    // BRAM for A: one cycle latency.
    always @(posedge clk) begin
        for (int c = 0; c < 4; c++) begin
            bdoutA[c*32 +: 32] <= wordAt(c, baddrA[c*32 +: 32]);
        end
    end

    // BRAM for B: three cycle latency.
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            pipeB[0][c*32 +: 32] <= wordAt(c, baddrB[c*32 +: 32]);
        end
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign bdoutB = pipeB[2];

    task automatic checkOutput(input string name, input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Abstract load model: a load takes KK+RD_LAT+1 edges, reads KK consecutive
    // bytes from where the previous one stopped, rewinds apply when idle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                mCursor[d] = '0; mStart[d] = '0; mPendAddr[d] = '0;
                mPend[d] = 0; mBusy[d] = 0; mLe[d] = 0; mT[d] = 0; mW[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                mLe[d] = 0;
                if (!mBusy[d]) begin
                    if (arS[d]) mCursor[d] = baseS[d];
                    else if (mPend[d]) mCursor[d] = mPendAddr[d];
                    mPend[d] = 0;
                    if (ldS[d]) begin
                        mBusy[d]   = 1;
                        mT[d]      = 0;
                        mStart[d]  = mCursor[d];
                        mCursor[d] = mCursor[d] + 32'(kkOf(d));
                    end
                end else begin
                    if (arS[d]) begin
                        mPend[d]     = 1;
                        mPendAddr[d] = baseS[d];
                    end
                    mT[d]++;
                    if (mT[d] == kkOf(d) + latOf(d) + 1) begin
                        mBusy[d] = 0;
                        mLe[d]   = 1;
                        mW[d]    = expWeights(d, mStart[d]);
                    end
                end
            end
        end
    end

    // Compare every observable output of both DUTs against the model each cycle.
    always @(negedge clk) begin
        if (chkEn) begin
            for (int d = 0; d < 2; d++) begin
                tag  = (d == 0) ? "A" : "B";
                obsW = (d == 0) ? 400'(weightA) : weightB;
                checkOutput({tag, ".busy"}, 400'((d == 0) ? busyA : busyB), 400'(mBusy[d]));
                checkOutput({tag, ".load_end"}, 400'((d == 0) ? leA : leB), 400'(mLe[d]));
                checkOutput({tag, ".weight"}, obsW, mW[d]);
                expAddr = (mBusy[d] && mT[d] < kkOf(d)) ? mStart[d] + 32'(mT[d]) : mCursor[d];
                for (int c = 0; c < nchOf(d); c++) begin
                    if (d == 0) obsAddr = baddrA[c*32 +: 32];
                    else        obsAddr = baddrB[c*32 +: 32];
                    checkOutput($sformatf("%s.addr%0d", tag, c), 400'(obsAddr), 400'(expAddr));
                end
            end
        end
    end

    // Request one load (optionally with a rewind) at a negedge and wait for load_end.
    task automatic applyStimulus(input int d, input bit rewind, input logic [31:0] base, output int lat);
        ldS[d]   = 1'b1;
        arS[d]   = rewind;
        baseS[d] = base;
        @(negedge clk);
        ldS[d] = 1'b0;
        arS[d] = 1'b0;
        lat = 0;
        while (!((d == 0) ? leA : leB) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        bit sawLe;
        passes = 0; checks = 0; fails = 0; chkEn = 0;
        for (int d = 0; d < 2; d++) begin
            ldS[d] = 1'b0; arS[d] = 1'b0; baseS[d] = '0;
        end
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset.busyA", 400'(busyA), 400'(0));
        checkOutput("reset.leA", 400'(leA), 400'(0));
        checkOutput("reset.weightA", 400'(weightA), 400'(0));
        checkOutput("reset.weightB", weightB, 400'(0));
        checkOutput("reset.addrA", 400'(baddrA), 400'(0));
        checkOutput("tied.A", 400'({bclkA, benA, brstA, bdinA, bwenA}), 400'({1'b0, 1'b1, 1'b0, 32'h0, 4'h0}));
        checkOutput("tied.B", 400'({bclkB, benB, brstB, bdinB, bwenB}), 400'({1'b0, 1'b1, 1'b0, 32'h0, 4'h0}));
        rst   = 1'b1;
        chkEn = 1;
        repeat (2) @(negedge clk);

        // A: first load from base 0
        applyStimulus(0, 1'b1, 32'h0, lat);
        checkOutput("A1.latency", 400'(lat), 400'(11));
        checkOutput("A1.ch0", 400'(weightA[71:0]), 400'(72'h000102030405060708));
        checkOutput("A1.ch1", 400'(weightA[143:72]), 400'(72'h101112131415161718));

        // A: back-to-back load in the load_end cycle
        applyStimulus(0, 1'b0, 32'h0, lat);
        checkOutput("A2.latency", 400'(lat), 400'(11));
        checkOutput("A2.ch0", 400'(weightA[71:0]), 400'(72'h090A0B0C0D0E0F1011));

        // A: rewind and a stray load_start while busy
        ldS[0] = 1'b1;
        @(negedge clk);
        ldS[0] = 1'b0;
        repeat (3) @(negedge clk);
        arS[0] = 1'b1; baseS[0] = 32'h100; ldS[0] = 1'b1;
        @(negedge clk);
        arS[0] = 1'b0; ldS[0] = 1'b0;
        lat = 4;
        while (!leA && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("A3.latency", 400'(lat), 400'(11));
        checkOutput("A3.ch0", 400'(weightA[71:0]), 400'(72'h12131415161718191A));
        applyStimulus(0, 1'b0, 32'h0, lat);
        checkOutput("A4.ch0", 400'(weightA[71:0]), 400'(72'h000102030405060708));
        checkOutput("A4.ch3", 400'(weightA[287:216]), 400'(72'h303132333435363738));

        // B: deep read latency, larger kernel
        applyStimulus(1, 1'b1, 32'h0, lat);
        checkOutput("B1.latency", 400'(lat), 400'(29));
        checkOutput("B1.ch0head", 400'(weightB[199:168]), 400'(32'h00010203));
        checkOutput("B1.ch0tail", 400'(weightB[7:0]), 400'(8'h18));
        checkOutput("B1.ch1head", 400'(weightB[399:368]), 400'(32'h10111213));

        // B: cursor wraps through zero
        applyStimulus(1, 1'b1, 32'hFFFF_FFFC, lat);
        checkOutput("B2.latency", 400'(lat), 400'(29));
        checkOutput("B2.ch0head", 400'(weightB[199:160]), 400'(40'hFCFDFEFF00));
        checkOutput("B2.ch0tail", 400'(weightB[7:0]), 400'(8'h14));
        checkOutput("B2.ch1head", 400'(weightB[399:368]), 400'(32'h0C0D0E0F));

        // A: asynchronous reset in the middle of a load
        ldS[0] = 1'b1;
        @(negedge clk);
        ldS[0] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("arst.weightA", 400'(weightA), 400'(0));
        checkOutput("arst.busyA", 400'(busyA), 400'(0));
        checkOutput("arst.addrA", 400'(baddrA), 400'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sawLe = 0;
        repeat (15) begin
            @(negedge clk);
            sawLe = sawLe | leA;
        end
        checkOutput("arst.noLoadEnd", 400'(sawLe), 400'(0));
        checkOutput("arst.weightHeld", 400'(weightA), 400'(0));
        applyStimulus(0, 1'b1, 32'h0, lat);
        checkOutput("A5.latency", 400'(lat), 400'(11));
        checkOutput("A5.ch0", 400'(weightA[71:0]), 400'(72'h000102030405060708));

        repeat (2) @(negedge clk);
        chkEn = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
